// File: rtl/mpc_cfg_ctrl.sv
// Wishbone-programmable configuration source for the pad/bus multiplexer.
// Every change runs drain -> switch -> settle with the pads isolated throughout.
module mpc_cfg_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [3:0]  RESET_CFG = 4'h0,
  parameter int unsigned GUARD_W   = 8,
  parameter int unsigned GUARD_RST = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  configuration,
  output logic        isolate,
  output logic        cfg_done
);

  localparam int unsigned DW = (GUARD_W > 4) ? GUARD_W : 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GUARD_W-1:0]   cnt_q, cnt_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic [3:0]           target_q, target_d;
  logic [3:0]           cfg_q, cfg_d;
  logic                 ovr_q, ovr_d;
  logic                 isolate_q, isolate_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 req_we_q, req_we_d;
  logic [7:0]           req_off_q, req_off_d;
  logic [3:0]           req_sel_q, req_sel_d;
  logic [DW-1:0]        req_dat_q, req_dat_d;

  logic                 hit, wr_cfg, wr_guard, wr_w1c;
  logic [GUARD_W-1:0]   guard_eff, gmask;
  logic [31:0]          rdata;
  logic                 unused_ok;

  assign unused_ok = ^{wbs_dat_i[31:DW], req_sel_q};

  // Bus front end: the request is captured on the hit and acted on during the ack cycle.
  always_comb begin
    hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    ack_d     = hit;
    req_we_d  = hit ? wbs_we_i : req_we_q;
    req_off_d = hit ? wbs_adr_i[7:0] : req_off_q;
    req_sel_d = hit ? wbs_sel_i : req_sel_q;
    req_dat_d = hit ? wbs_dat_i[DW-1:0] : req_dat_q;

    unique case (wbs_adr_i[7:0])
      8'h00:   rdata = 32'(cfg_q);
      8'h04:   rdata = 32'(guard_q);
      8'h08:   rdata = 32'({ovr_q, state_q, (state_q != IDLE)});
      default: rdata = 32'h0;
    endcase
    dat_d = (hit && !wbs_we_i) ? rdata : 32'h0;
  end

  always_comb begin
    wr_cfg   = ack_q & req_we_q & (req_off_q == 8'h00) & req_sel_q[0];
    wr_guard = ack_q & req_we_q & (req_off_q == 8'h04);
    wr_w1c   = ack_q & req_we_q & (req_off_q == 8'h08) & req_sel_q[0] & req_dat_q[3];
    guard_eff = (guard_q == '0) ? GUARD_W'(1) : guard_q;
    for (int i = 0; i < int'(GUARD_W); i++) gmask[i] = req_sel_q[i / 8];
    guard_d = wr_guard ? ((guard_q & ~gmask) | (req_dat_q[GUARD_W-1:0] & gmask)) : guard_q;
  end

  // Sequencer: guard counters hold at 1 rather than wrapping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    cfg_d    = cfg_q;
    ovr_d    = ovr_q;
    done_d   = 1'b0;

    if (wr_w1c) ovr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_cfg && (req_dat_q[3:0] != cfg_q)) begin
          target_d = req_dat_q[3:0];
          cnt_d    = guard_eff;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q <= GUARD_W'(1)) state_d = SWITCH;
        else                      cnt_d   = cnt_q - GUARD_W'(1);
      end
      SWITCH: begin
        cfg_d   = target_q;
        cnt_d   = guard_eff;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q <= GUARD_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - GUARD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A dropped write must win over a simultaneous clear.
    if (wr_cfg && (state_q != IDLE)) ovr_d = 1'b1;

    isolate_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      guard_q   <= GUARD_W'(GUARD_RST);
      target_q  <= RESET_CFG;
      cfg_q     <= RESET_CFG;
      ovr_q     <= 1'b0;
      isolate_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      req_we_q  <= 1'b0;
      req_off_q <= 8'h00;
      req_sel_q <= 4'h0;
      req_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      guard_q   <= guard_d;
      target_q  <= target_d;
      cfg_q     <= cfg_d;
      ovr_q     <= ovr_d;
      isolate_q <= isolate_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      req_we_q  <= req_we_d;
      req_off_q <= req_off_d;
      req_sel_q <= req_sel_d;
      req_dat_q <= req_dat_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign configuration = cfg_q;
  assign isolate       = isolate_q;
  assign cfg_done      = done_q;

endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// Directed bench for mpc_cfg_ctrl: bus transactions are scoreboarded through a queue,
// and isolate/done/configuration windows are checked against expected guard lengths.
module tb_mpc_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [3:0]  configuration;
  logic        isolate, cfg_done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mpc_cfg_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .configuration(configuration), .isolate(isolate), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction, started on a falling edge; ends one idle cycle after the ack.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_rd, input string tag);
    logic got;
    int   lat;
    logic [31:0] e;
    exp_q.push_back(w ? 32'h0 : exp_rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; lat = i; end
    end
    e = exp_q.pop_front();
    if (got) begin
      check({tag, "_lat"}, 32'(lat), 32'd1);
      check({tag, "_dat"}, dat_o, e);
    end else begin
      check({tag, "_ack_timeout"}, 32'(ack), 32'd1);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check({tag, "_ack_1cyc"}, 32'(ack), 32'd0);
  endtask

  // Watches a sequence window starting at the current falling edge.
  task automatic observe(input int exp_len, input logic [3:0] old_cfg,
                         input logic [3:0] new_cfg, input string tag);
    int   iso_n, done_n;
    logic rose, fell, done_ok, bad_cfg, mid;
    logic [31:0] exp_seq;
    iso_n = 0; done_n = 0; rose = 0; fell = 0; done_ok = 0; bad_cfg = 0; mid = 0;
    exp_seq = (exp_len > 0) ? 32'd1 : 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (isolate) begin iso_n++; rose = 1'b1; end
      if (cfg_done) begin
        done_n++;
        if (rose && !isolate && !fell) done_ok = 1'b1;
      end
      if (!isolate && !rose && configuration !== old_cfg) bad_cfg = 1'b1;
      if (!isolate && rose && configuration !== new_cfg) bad_cfg = 1'b1;
      if (isolate && configuration === new_cfg && old_cfg != new_cfg) mid = 1'b1;
      if (rose && !isolate) fell = 1'b1;
      @(negedge clk);
    end
    check({tag, "_iso_len"}, 32'(iso_n), 32'(exp_len));
    check({tag, "_done_cnt"}, 32'(done_n), exp_seq);
    check({tag, "_done_align"}, 32'(done_ok), exp_seq);
    check({tag, "_cfg_outside_iso"}, 32'(bad_cfg), 32'd0);
    check({tag, "_cfg_mid"}, 32'(mid), exp_seq);
    check({tag, "_cfg_final"}, 32'(configuration), 32'(new_cfg));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && isolate; i++) @(negedge clk);
    check({tag, "_idle"}, 32'(isolate), 32'd0);
  endtask

  initial begin
    int acks;
    rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_cfg", 32'(configuration), 32'h0);
    check("rst_iso", 32'(isolate), 32'h0);
    check("rst_done", 32'(cfg_done), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Reset register values
    bus(0, 32'h3000_0000, 0, 4'hF, 32'h0,  "rd_cfg_rst");
    bus(0, 32'h3000_0004, 0, 4'hF, 32'h10, "rd_guard_rst");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h0,  "rd_stat_rst");

    // G=3: 7-cycle isolate window, 0 -> 5
    bus(1, 32'h3000_0004, 32'h3, 4'hF, 0, "wr_guard3");
    bus(0, 32'h3000_0004, 0, 4'hF, 32'h3, "rd_guard3");
    bus(1, 32'h3000_0000, 32'h5, 4'h1, 0, "wr_cfg5");
    observe(7, 4'h0, 4'h5, "seq5");
    bus(0, 32'h3000_0000, 0, 4'hF, 32'h5, "rd_cfg5");

    // Same value: no sequence
    bus(1, 32'h3000_0000, 32'h5, 4'h1, 0, "wr_cfg5_same");
    observe(0, 4'h5, 4'h5, "same5");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h0, "rd_stat_same");

    // Overrun during DRAIN
    bus(1, 32'h3000_0000, 32'h0, 4'h1, 0, "wr_cfg0");
    observe(7, 4'h5, 4'h0, "seq0");
    bus(1, 32'h3000_0004, 32'h8, 4'h1, 0, "wr_guard8");
    bus(1, 32'h3000_0000, 32'h5, 4'h1, 0, "wr_cfg5b");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h3, "rd_stat_drain");
    bus(1, 32'h3000_0000, 32'hA, 4'h1, 0, "wr_cfgA_busy");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'hB, "rd_stat_ovr");
    wait_idle("ovr");
    check("ovr_final_cfg", 32'(configuration), 32'h5);
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h8, "rd_stat_ovr_idle");
    bus(1, 32'h3000_0008, 32'h8, 4'h1, 0, "w1c_ovr");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h0, "rd_stat_clr");

    // GUARD=0 behaves as 1
    bus(1, 32'h3000_0004, 32'h0, 4'hF, 0, "wr_guard0");
    bus(0, 32'h3000_0004, 0, 4'hF, 32'h0, "rd_guard0");
    bus(1, 32'h3000_0000, 32'h9, 4'h1, 0, "wr_cfg9");
    observe(3, 4'h5, 4'h9, "seq9");

    // Address outside the window
    acks = 0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("miss_no_ack", 32'(acks), 32'h0);
    @(negedge clk);

    // Asynchronous reset in SETTLE
    bus(1, 32'h3000_0004, 32'h3, 4'h1, 0, "wr_guard3b");
    bus(1, 32'h3000_0000, 32'h6, 4'h1, 0, "wr_cfg6");
    repeat (4) @(negedge clk);
    check("settle_cfg6", 32'(configuration), 32'h6);
    check("settle_iso", 32'(isolate), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_cfg", 32'(configuration), 32'h0);
    check("arst_iso", 32'(isolate), 32'h0);
    check("arst_done", 32'(cfg_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_hold_done", 32'(cfg_done), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(cfg_done), 32'h0);
    end
    bus(0, 32'h3000_0000, 0, 4'hF, 32'h0,  "rd_cfg_after_rst");
    bus(0, 32'h3000_0004, 0, 4'hF, 32'h10, "rd_guard_after_rst");
    bus(0, 32'h3000_0008, 0, 4'hF, 32'h0,  "rd_stat_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
